// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
//   Shared encodings for the HI/LO multiply/divide unit: the op field
//   driven by the decoder and the FSM state constants used by the top.
//   The constants are plain sized localparams so that older tools and
//   the surrounding pipeline code can use them without an enum cast.
package mult_div_unit_pkg;

  // op field values
  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  // FSM states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // MULT and DIV treat their operands as two's complement; MULTU/DIVU do not.
  function automatic logic mdu_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_core_step.sv
// mdu_core_step
//   One combinational iteration of the iterative multiply/divide datapath.
//   The accumulator is 2*WIDTH+1 bits wide.
//   is_div = 0 : shift-add multiply step. acc[2W:W] is the running partial
//                product, acc[W-1:0] the remaining multiplier bits (LSB first).
//   is_div = 1 : restoring-divide step. acc[2W:W] is the partial remainder,
//                acc[W-1:0] holds the dividend bits still to be shifted in
//                (MSB first) with quotient bits entering at the bottom.
// Ports
//   is_div   in   1          select divide (1) or multiply (0) step
//   acc_in   in   2*WIDTH+1  accumulator before the step
//   opnd     in   WIDTH      multiplicand / divisor magnitude
//   acc_out  out  2*WIDTH+1  accumulator after the step
module mdu_core_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   acc_in,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH:0]   acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    // The multiply partial product never exceeds 2^WIDTH-1 before the add
    // because the previous shift cleared the top bit, so WIDTH+1 bits hold the sum.
    sum    = acc_in[2*WIDTH:WIDTH] + {1'b0, (acc_in[0] ? opnd : {WIDTH{1'b0}})};
    // Next dividend bit shifted into the partial remainder.
    rem_sh = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, opnd};
    acc_out = {1'b0, sum, acc_in[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        acc_out = {diff[WIDTH:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {rem_sh, acc_in[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
//   A MULT/DIV runs on unsigned magnitudes for WIDTH iterations, then a
//   single fix-up cycle applies signs and writes HI/LO. MTHI/MTLO write
//   directly at the accepting edge.
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request, honoured only while idle
//   op     in   3      operation select (see mult_div_unit_pkg)
//   a      in   WIDTH  rs operand
//   b      in   WIDTH  rt operand
//   busy   out  1      MULT/DIV in flight
//   done   out  1      one-cycle pulse when HI/LO take a MULT/DIV result
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = 2 * WIDTH + 1;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             is_div_q, is_div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [AW-1:0]      step_acc;
  logic               sgn_a, sgn_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  mdu_core_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .acc_in  (acc_q),
    .opnd    (opnd_q),
    .acc_out (step_acc)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sgn_a      = mdu_is_signed(op) & a[WIDTH-1];
    sgn_b      = mdu_is_signed(op) & b[WIDTH-1];
    prod       = acc_q[2*WIDTH-1:0];
    quot       = acc_q[WIDTH-1:0];
    rem        = acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              // Dividend / multiplier magnitude sits in the low half;
              // the other magnitude is the per-step operand.
              acc_d      = {{(WIDTH+1){1'b0}}, (sgn_a ? -a : a)};
              opnd_d     = sgn_b ? -b : b;
              a_raw_d    = a;
              is_div_d   = op[1];
              neg_a_d    = sgn_a;
              neg_b_d    = sgn_b;
              div_zero_d = (b == '0);
              cnt_d      = '0;
              busy_d     = 1'b1;
              state_d    = S_RUN;
            end
            default: ;  // reserved encodings are treated as no request
          endcase
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (!is_div_q) begin
          if (neg_a_q ^ neg_b_q) begin
            prod = -acc_q[2*WIDTH-1:0];
          end
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (div_zero_q) begin
          // Divide by zero reports the raw dividend, not the sign-fixed one.
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          if (neg_a_q ^ neg_b_q) begin
            quot = -acc_q[WIDTH-1:0];
          end
          if (neg_a_q) begin
            rem = -acc_q[2*WIDTH-1:WIDTH];
          end
          hi_d = rem;
          lo_d = quot;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed-vector bench for mult_div_unit with hand-computed results.
//   Inputs change on the falling edge; outputs are sampled 1 ns after the
//   rising edge.
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one MULT/DIV and check the whole timeline: busy from the issue
  // edge, HI/LO frozen for 32 edges, result + done at edge 33, done low at 34.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int bad;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    old_hi = hi; old_lo = lo;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b1 || hi !== old_hi || lo !== old_lo) bad++;
    end
    check({tag, "_run_bad_cycles"}, bad, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    $display("op %0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h", o, x, y, hi, lo);
  endtask

  // Single-edge request (MTHI/MTLO/reserved); returns after the sampling point.
  task automatic pulse_op(input logic [2:0] o, input logic [31:0] x);
    @(negedge clk);
    op = o; a = x; b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    $display("op %0d a=0x%08h -> hi=0x%08h lo=0x%08h busy=%0b", o, x, hi, lo, busy);
  endtask

  initial begin
    int bad;
    int n;
    rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // MTHI / MTLO
    pulse_op(3'b100, 32'h12345678);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    pulse_op(3'b101, 32'h0BADF00D);
    check("mtlo_lo", lo, 32'h0BADF00D);
    check("mtlo_hi_kept", hi, 32'h12345678);

    // Reserved op is a no-op
    pulse_op(3'b110, 32'hDEADBEEF);
    check("rsv_busy", {31'd0, busy}, 32'd0);
    check("rsv_hi", hi, 32'h12345678);
    check("rsv_lo", lo, 32'h0BADF00D);

    // Reset mid-MULT
    @(negedge clk);
    op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_hi", hi, 32'd0);
    check("rstmid_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("rstmid_no_done", bad, 32'd0);
    $display("reset mid-MULT -> hi=0x%08h lo=0x%08h", hi, lo);

    // Multiply
    run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_negneg", 3'b000, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006);

    // Divide
    run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_zero", 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_op("div_zero_neg", 3'b010, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_pos_negb", 3'b010, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

    // MTLO during RUN is ignored: start a MULT (6*7), try MTLO mid-flight
    @(negedge clk);
    op = 3'b000; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = 3'b101; a = 32'h55555555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_run_lo", lo, 32'hFFFFFFFD);
    check("mtlo_run_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("mtlo_run_done_seen", {31'd0, done}, 32'd1);
    check("mtlo_run_result_lo", lo, 32'd42);
    check("mtlo_run_result_hi", hi, 32'd0);
    $display("MTLO during RUN -> hi=0x%08h lo=0x%08h", hi, lo);

    // Back-to-back: start held high; second MULT only after done
    @(negedge clk);
    op = 3'b001; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    a = 32'h00010000; b = 32'h00010000;  // operands of the second request
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1 || done !== 1'b0 || lo !== 32'd42 || hi !== 32'd0) bad++;
    end
    check("b2b_first_run", bad, 32'd0);
    @(posedge clk); #1;
    check("b2b_first_done", {31'd0, done}, 32'd1);
    check("b2b_first_busy", {31'd0, busy}, 32'd0);
    check("b2b_first_lo", lo, 32'd15);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_second_busy", {31'd0, busy}, 32'd1);
    check("b2b_second_nodone", {31'd0, done}, 32'd0);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_second_latency", n, 32'd33);
    check("b2b_second_hi", hi, 32'h00000001);
    check("b2b_second_lo", lo, 32'h00000000);
    $display("back-to-back second MULTU -> hi=0x%08h lo=0x%08h after %0d cycles", hi, lo, n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
